// File: rtl/stream_mux_4x1_pkg.sv
// Shared constants and types for the 4:1 stream multiplexer.
package stream_mux_pkg;
  localparam int NCH  = 4;
  localparam int TAGW = 2;

  typedef logic [TAGW-1:0] ch_t;

  localparam ch_t PTR_RST = 2'd3;
endpackage

// File: rtl/stream_mux_4x1_if.sv
// Lane/output handshake bundle: four producer lanes in, one tagged stream out.
interface stream_mux_4x1_if #(parameter int DW = 8);
  logic          mode, s1, s0;
  logic [DW-1:0] i0, i1, i2, i3;
  logic          v0, v1, v2, v3;
  logic          r0, r1, r2, r3;
  logic [DW-1:0] y;
  logic          y_vld, y_rdy;
  logic [1:0]    ch;

  modport master (
    output mode, s1, s0, i0, i1, i2, i3, v0, v1, v2, v3, y_rdy,
    input  r0, r1, r2, r3, y, y_vld, ch
  );

  modport slave (
    input  mode, s1, s0, i0, i1, i2, i3, v0, v1, v2, v3, y_rdy,
    output r0, r1, r2, r3, y, y_vld, ch
  );
endinterface

// File: rtl/stream_mux_4x1_rr_arb4.sv
// Combinational 4-way arbiter: round-robin from ptr+1, or fixed select.
module rr_arb4
  import stream_mux_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  ch_t            ptr,
  input  logic           mode,
  input  ch_t            sel,
  output ch_t            gnt,
  output logic           gnt_vld
);
  always_comb begin
    gnt     = sel;
    gnt_vld = 1'b0;
    if (mode) begin
      gnt_vld = req[sel];
    end else begin
      // Walk farthest-to-nearest so the lane closest after ptr overwrites last.
      for (int k = NCH; k >= 1; k--) begin
        if (req[ptr + ch_t'(k)]) begin
          gnt     = ptr + ch_t'(k);
          gnt_vld = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/stream_mux_4x1.sv
// Registered 4:1 stream mux with round-robin or fixed-select arbitration and a source tag.
module stream_mux_4x1
  import stream_mux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  stream_mux_4x1_if.slave   bus
);
  logic [NCH-1:0][DW-1:0] lane_d;
  logic [NCH-1:0]         req, rdy;
  ch_t                    ptr, gnt, ch_q;
  logic                   gnt_vld, load, y_vld_q;
  logic [DW-1:0]          y_q;

  assign lane_d = {bus.i3, bus.i2, bus.i1, bus.i0};
  assign req    = {bus.v3, bus.v2, bus.v1, bus.v0};
  assign load   = !y_vld_q || bus.y_rdy;

  rr_arb4 u_arb (
    .req     (req),
    .ptr     (ptr),
    .mode    (bus.mode),
    .sel     ({bus.s1, bus.s0}),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  // Ready is one-hot on the granted lane; gnt_vld already implies that lane is valid.
  for (genvar n = 0; n < NCH; n++) begin : g_rdy
    assign rdy[n] = !rst && load && gnt_vld && (gnt == ch_t'(n));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      ch_q    <= '0;
      y_vld_q <= 1'b0;
      ptr     <= PTR_RST;
    end else if (load) begin
      if (gnt_vld) begin
        y_q     <= lane_d[gnt];
        ch_q    <= gnt;
        y_vld_q <= 1'b1;
        if (!bus.mode) ptr <= gnt;
      end else begin
        y_vld_q <= 1'b0;
      end
    end
  end

  assign bus.r0    = rdy[0];
  assign bus.r1    = rdy[1];
  assign bus.r2    = rdy[2];
  assign bus.r3    = rdy[3];
  assign bus.y     = y_q;
  assign bus.ch    = ch_q;
  assign bus.y_vld = y_vld_q;
endmodule

// File: tb/tb_stream_mux_4x1.sv
// Directed bench for stream_mux_4x1 with hand-computed expectations.
module tb_stream_mux_4x1;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stream_mux_4x1_if #(.DW(8)) bus ();

  stream_mux_4x1 #(.DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_v(input logic [3:0] v);
    {bus.v3, bus.v2, bus.v1, bus.v0} = v;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [7:0] y, input logic [1:0] ch);
    chk({tag, ".vld"}, 32'(bus.y_vld), 32'(vld));
    chk({tag, ".y"},   32'(bus.y),     32'(y));
    chk({tag, ".ch"},  32'(bus.ch),    32'(ch));
  endtask

  function automatic logic [3:0] rv();
    return {bus.r3, bus.r2, bus.r1, bus.r0};
  endfunction

  logic [7:0] rr_y [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

  initial begin
    rst = 1'b1;
    bus.mode = 1'b0; bus.s1 = 1'b0; bus.s0 = 1'b0; bus.y_rdy = 1'b1;
    bus.i0 = 8'h10; bus.i1 = 8'h21; bus.i2 = 8'h32; bus.i3 = 8'h43;
    set_v(4'b1111);

    // reset with all lanes valid
    tick(); tick();
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    chk("rst.r", 32'(rv()), 32'h0);
    rst = 1'b0; #1;
    chk("first.r", 32'(rv()), 32'b0001);

    // round-robin fairness
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out($sformatf("rr%0d", k), 1'b1, rr_y[k], 2'(k % 4));
    end
    tick();
    chk_out("rr5", 1'b1, 8'h21, 2'd1);

    // backpressure: hold 21/ch1, then zero-bubble accept of lane 2
    bus.y_rdy = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d.r", k), 32'(rv()), 32'h0);
      tick();
      chk_out($sformatf("bp%0d", k), 1'b1, 8'h21, 2'd1);
    end
    bus.y_rdy = 1'b1; #1;
    chk("bp.release.r", 32'(rv()), 32'b0100);
    tick();
    chk_out("bp.next", 1'b1, 8'h32, 2'd2);

    // sparse requests
    bus.i2 = 8'hA5; set_v(4'b0100);
    chk("sp2.r", 32'(rv()), 32'b0100);
    tick();
    chk_out("sp2", 1'b1, 8'hA5, 2'd2);
    bus.i0 = 8'h5A; set_v(4'b0001);
    chk("sp0.r", 32'(rv()), 32'b0001);
    tick();
    chk_out("sp0", 1'b1, 8'h5A, 2'd0);
    set_v(4'b0000);
    chk("idle.r", 32'(rv()), 32'h0);
    tick();
    chk_out("idle", 1'b0, 8'h5A, 2'd0);

    // fixed select lane 2
    bus.i0 = 8'h10; bus.i2 = 8'h32;
    bus.mode = 1'b1; bus.s1 = 1'b1; bus.s0 = 1'b0;
    set_v(4'b1111);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fx%0d.r", k), 32'(rv()), 32'b0100);
      tick();
      chk_out($sformatf("fx%0d", k), 1'b1, 8'h32, 2'd2);
    end
    set_v(4'b1011);
    chk("fx.nogrant.r", 32'(rv()), 32'h0);
    tick();
    chk("fx.nogrant.vld", 32'(bus.y_vld), 32'h0);

    // back to round-robin: ptr still 0 from last RR winner, so lane 1 next
    bus.mode = 1'b0;
    set_v(4'b1111);
    chk("resume.r", 32'(rv()), 32'b0010);
    tick();
    chk_out("resume", 1'b1, 8'h21, 2'd1);

    // reset mid-stream while stalled
    bus.y_rdy = 1'b0;
    rst = 1'b1; #1;
    chk("midrst.r", 32'(rv()), 32'h0);
    tick();
    chk_out("midrst", 1'b0, 8'h00, 2'd0);
    rst = 1'b0; bus.y_rdy = 1'b1; #1;
    chk("postrst.r", 32'(rv()), 32'b0001);
    tick();
    chk_out("postrst", 1'b1, 8'h10, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
